// File: rtl/exec_ctrl.sv
// Single-slot execute controller: holds one decoded instruction in EX, resolves
// read-after-write hazards by a one-cycle stall, registers writeback and fetch redirects.
module exec_ctrl #(
  parameter int WIDTH            = 32,
  parameter int REG_WIDTH        = 5,
  parameter int INSTR_TYPE_WIDTH = 8,
  parameter int FLUSH_CYCLES     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INSTR_TYPE_WIDTH-1:0] in_type,
  input  logic [REG_WIDTH-1:0]        in_rd,
  input  logic [REG_WIDTH-1:0]        in_rs1,
  input  logic [REG_WIDTH-1:0]        in_rs2,
  input  logic [WIDTH-1:0]            in_pc,
  input  logic [WIDTH-1:0]            in_imm,
  output logic [INSTR_TYPE_WIDTH-1:0] alu_type,
  output logic [WIDTH-1:0]            alu_pc,
  output logic [WIDTH-1:0]            alu_imm,
  output logic [REG_WIDTH-1:0]        alu_rs1_idx,
  output logic [REG_WIDTH-1:0]        alu_rs2_idx,
  input  logic [WIDTH-1:0]            alu_result,
  input  logic                        alu_taken,
  output logic                        wb_valid,
  output logic [REG_WIDTH-1:0]        wb_rd,
  output logic [WIDTH-1:0]            wb_data,
  output logic                        redirect_valid,
  output logic [WIDTH-1:0]            redirect_pc
);

  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_ADD   = INSTR_TYPE_WIDTH'(1);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_SUB   = INSTR_TYPE_WIDTH'(2);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_AND   = INSTR_TYPE_WIDTH'(3);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_OR    = INSTR_TYPE_WIDTH'(4);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_XOR   = INSTR_TYPE_WIDTH'(5);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_SLL   = INSTR_TYPE_WIDTH'(6);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_SRL   = INSTR_TYPE_WIDTH'(7);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_SRA   = INSTR_TYPE_WIDTH'(8);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_SLT   = INSTR_TYPE_WIDTH'(9);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_SLTU  = INSTR_TYPE_WIDTH'(10);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_ADDI  = INSTR_TYPE_WIDTH'(11);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_ANDI  = INSTR_TYPE_WIDTH'(12);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_ORI   = INSTR_TYPE_WIDTH'(13);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_XORI  = INSTR_TYPE_WIDTH'(14);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_SLTI  = INSTR_TYPE_WIDTH'(15);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_SLTIU = INSTR_TYPE_WIDTH'(16);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_SLLI  = INSTR_TYPE_WIDTH'(17);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_SRLI  = INSTR_TYPE_WIDTH'(18);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_SRAI  = INSTR_TYPE_WIDTH'(19);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_LUI   = INSTR_TYPE_WIDTH'(20);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_AUIPC = INSTR_TYPE_WIDTH'(21);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_JAL   = INSTR_TYPE_WIDTH'(22);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_JALR  = INSTR_TYPE_WIDTH'(23);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_BEQ   = INSTR_TYPE_WIDTH'(24);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_BNE   = INSTR_TYPE_WIDTH'(25);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_BLT   = INSTR_TYPE_WIDTH'(26);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_BGE   = INSTR_TYPE_WIDTH'(27);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_BLTU  = INSTR_TYPE_WIDTH'(28);
  localparam logic [INSTR_TYPE_WIDTH-1:0] IS_BGEU  = INSTR_TYPE_WIDTH'(29);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  function automatic logic is_branch(input logic [INSTR_TYPE_WIDTH-1:0] t);
    case (t)
      IS_BEQ, IS_BNE, IS_BLT, IS_BGE, IS_BLTU, IS_BGEU: is_branch = 1'b1;
      default:                                          is_branch = 1'b0;
    endcase
  endfunction

  function automatic logic is_jump(input logic [INSTR_TYPE_WIDTH-1:0] t);
    is_jump = (t == IS_JAL) || (t == IS_JALR);
  endfunction

  // Unknown codes fall to default so they travel through EX without side effects.
  function automatic logic writes_rd(input logic [INSTR_TYPE_WIDTH-1:0] t);
    case (t)
      IS_ADD, IS_SUB, IS_AND, IS_OR, IS_XOR, IS_SLL, IS_SRL, IS_SRA,
      IS_SLT, IS_SLTU, IS_ADDI, IS_ANDI, IS_ORI, IS_XORI, IS_SLTI,
      IS_SLTIU, IS_SLLI, IS_SRLI, IS_SRAI, IS_LUI, IS_AUIPC,
      IS_JAL, IS_JALR: writes_rd = 1'b1;
      default:         writes_rd = 1'b0;
    endcase
  endfunction

  logic [1:0]                  state_q, state_d;
  logic [3:0]                  flush_cnt_q, flush_cnt_d;
  logic                        ex_valid_q, ex_valid_d;
  logic [INSTR_TYPE_WIDTH-1:0] ex_type_q;
  logic [REG_WIDTH-1:0]        ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic [WIDTH-1:0]            ex_pc_q, ex_imm_q;

  logic                        wb_valid_q, wb_valid_d;
  logic [REG_WIDTH-1:0]        wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0]            wb_data_q, wb_data_d;
  logic                        redir_valid_q, redir_valid_d;
  logic [WIDTH-1:0]            redir_pc_q, redir_pc_d;

  logic ex_writes, ex_ctrl_flow, redirect_now, hazard, accept, load_ex;
  logic [WIDTH-1:0] redir_target;

  always_comb begin
    ex_writes    = ex_valid_q && writes_rd(ex_type_q) && (ex_rd_q != '0);
    ex_ctrl_flow = ex_valid_q && (is_branch(ex_type_q) || is_jump(ex_type_q));
    redirect_now = ex_ctrl_flow && alu_taken;
    hazard       = (state_q == ST_RUN) && ex_writes &&
                   ((in_rs1 == ex_rd_q) || (in_rs2 == ex_rd_q));
    // A redirecting cycle discards whatever arrives, so a hazard there is moot.
    in_ready     = !(hazard && !redirect_now);
    accept       = in_valid && in_ready;
    load_ex      = accept && (state_q != ST_FLUSH) && !redirect_now;
  end

  always_comb begin
    redir_target = ex_pc_q + ex_imm_q;
    if (ex_type_q == IS_JAL) begin
      redir_target = alu_result;
    end else if (ex_type_q == IS_JALR) begin
      redir_target = alu_result & ~WIDTH'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (redirect_now) begin
      // The slot alongside the redirect is the first discarded one.
      if (FLUSH_CYCLES > 1) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FLUSH_LOAD;
      end else begin
        state_d     = ST_RUN;
        flush_cnt_d = 4'd0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard && in_valid) state_d = ST_STALL;
        end
        ST_STALL: state_d = ST_RUN;
        ST_FLUSH: begin
          flush_cnt_d = flush_cnt_q - 4'd1;
          if (flush_cnt_q <= 4'd1) begin
            state_d     = ST_RUN;
            flush_cnt_d = 4'd0;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    ex_valid_d    = load_ex;
    wb_valid_d    = ex_writes;
    wb_rd_d       = ex_writes ? ex_rd_q : '0;
    wb_data_d     = '0;
    if (ex_writes) begin
      wb_data_d = is_jump(ex_type_q) ? (ex_pc_q + WIDTH'(4)) : alu_result;
    end
    redir_valid_d = redirect_now;
    redir_pc_d    = redirect_now ? redir_target : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      flush_cnt_q   <= 4'd0;
      ex_valid_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      ex_valid_q    <= ex_valid_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  // EX payload is qualified by ex_valid_q everywhere, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_ex) begin
      ex_type_q <= in_type;
      ex_rd_q   <= in_rd;
      ex_rs1_q  <= in_rs1;
      ex_rs2_q  <= in_rs2;
      ex_pc_q   <= in_pc;
      ex_imm_q  <= in_imm;
    end
  end

  assign alu_type       = ex_valid_q ? ex_type_q : '0;
  assign alu_pc         = ex_valid_q ? ex_pc_q   : '0;
  assign alu_imm        = ex_valid_q ? ex_imm_q  : '0;
  assign alu_rs1_idx    = ex_valid_q ? ex_rs1_q  : '0;
  assign alu_rs2_idx    = ex_valid_q ? ex_rs2_q  : '0;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Scoreboard bench for exec_ctrl: a slot-level reference model predicts in_ready,
// ALU-side outputs and every writeback/redirect, which are compared as the DUT emits them.
module tb_exec_ctrl;
  localparam int FC = 2;

  localparam logic [7:0] T_ADD = 8'd1, T_ADDI = 8'd11, T_LUI = 8'd20;
  localparam logic [7:0] T_JAL = 8'd22, T_JALR = 8'd23;
  localparam logic [7:0] T_BEQ = 8'd24, T_BNE = 8'd25, T_BGEU = 8'd29;
  localparam logic [7:0] T_UNK = 8'hEE;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [7:0]  in_type;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_pc, in_imm;
  logic [7:0]  alu_type;
  logic [31:0] alu_pc, alu_imm, alu_result;
  logic [4:0]  alu_rs1_idx, alu_rs2_idx;
  logic        alu_taken;
  logic        wb_valid, redirect_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, redirect_pc;

  exec_ctrl #(.WIDTH(32), .REG_WIDTH(5), .INSTR_TYPE_WIDTH(8), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .alu_type(alu_type), .alu_pc(alu_pc), .alu_imm(alu_imm),
    .alu_rs1_idx(alu_rs1_idx), .alu_rs2_idx(alu_rs2_idx),
    .alu_result(alu_result), .alu_taken(alu_taken),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: result = imm + 2*rs1 index, taken when both source indices match.
  function automatic logic [31:0] alu_fn(input logic [31:0] imm, input logic [4:0] rs1);
    return imm + {26'd0, rs1, 1'b0};
  endfunction
  assign alu_result = alu_fn(alu_imm, alu_rs1_idx);
  assign alu_taken  = (alu_rs1_idx == alu_rs2_idx);

  function automatic logic t_jump(input logic [7:0] t);
    return (t == T_JAL) || (t == T_JALR);
  endfunction
  function automatic logic t_branch(input logic [7:0] t);
    return t inside {[T_BEQ:T_BGEU]};
  endfunction
  function automatic logic t_writes(input logic [7:0] t);
    return t inside {[8'd1:T_JALR]};
  endfunction

  typedef struct {
    int          cyc;
    logic        wv;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        rv;
    logic [31:0] rpc;
  } ev_t;
  ev_t sb[$];

  int n_tests = 0, n_fail = 0, cyc = 0;

  logic        m_v;
  logic [7:0]  m_type;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [31:0] m_pc, m_imm;
  int          m_drop;
  logic        dut_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_v = 1'b0; m_type = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    m_pc = '0; m_imm = '0; m_drop = 0;
    sb.delete();
  endtask

  task automatic check_outputs();
    ev_t e;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("wb_valid", {63'd0, wb_valid}, {63'd0, e.wv});
      chk("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
      chk("wb_data", {32'd0, wb_data}, {32'd0, e.wd});
      chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, e.rv});
      chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, e.rpc});
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("sb_stale_event", 64'(cyc), 64'(sb[0].cyc));
      void'(sb.pop_front());
    end else begin
      chk("idle_wb_valid", {63'd0, wb_valid}, 64'd0);
      chk("idle_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    end
  endtask

  task automatic model_slot();
    logic taken, wr, haz, exp_rdy, acc;
    ev_t  e;
    taken   = m_v && (t_branch(m_type) || t_jump(m_type)) && (m_rs1 == m_rs2);
    wr      = m_v && t_writes(m_type) && (m_rd != 0);
    haz     = wr && ((in_rs1 == m_rd) || (in_rs2 == m_rd));
    exp_rdy = !(haz && !taken);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    chk("alu_type", {56'd0, alu_type}, m_v ? {56'd0, m_type} : 64'd0);
    chk("alu_pc", {32'd0, alu_pc}, m_v ? {32'd0, m_pc} : 64'd0);
    chk("alu_rs1_idx", {59'd0, alu_rs1_idx}, m_v ? {59'd0, m_rs1} : 64'd0);
    if (wr || taken) begin
      e.cyc = cyc + 1;
      e.wv  = wr;
      e.rd  = wr ? m_rd : 5'd0;
      e.wd  = !wr ? 32'd0 : t_jump(m_type) ? m_pc + 32'd4 : alu_fn(m_imm, m_rs1);
      e.rv  = taken;
      e.rpc = !taken ? 32'd0 :
              t_branch(m_type) ? m_pc + m_imm :
              (m_type == T_JAL) ? alu_fn(m_imm, m_rs1) : (alu_fn(m_imm, m_rs1) & ~32'd1);
      sb.push_back(e);
    end
    acc = in_valid && exp_rdy;
    if (taken) begin
      m_v = 1'b0; m_drop = FC - 1;
    end else if (m_drop > 0) begin
      m_v = 1'b0; m_drop--;
    end else begin
      m_v = acc;
      if (acc) begin
        m_type = in_type; m_rd = in_rd; m_rs1 = in_rs1; m_rs2 = in_rs2;
        m_pc = in_pc; m_imm = in_imm;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    dut_acc = in_valid && in_ready;
    check_outputs();
    model_slot();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue(input logic [7:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] pc, input logic [31:0] imm,
                       output int waited);
    waited = 0;
    in_valid = 1'b1; in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_pc = pc; in_imm = imm;
    step();
    while (!dut_acc && waited < 8) begin
      waited++;
      step();
    end
    if (!dut_acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd0);
    chk({tag, "_wb_rd"}, {59'd0, wb_rd}, 64'd0);
    chk({tag, "_wb_data"}, {32'd0, wb_data}, 64'd0);
    chk({tag, "_redirect_valid"}, {63'd0, redirect_valid}, 64'd0);
    chk({tag, "_redirect_pc"}, {32'd0, redirect_pc}, 64'd0);
    chk({tag, "_alu_type"}, {56'd0, alu_type}, 64'd0);
    chk({tag, "_alu_pc"}, {32'd0, alu_pc}, 64'd0);
    chk({tag, "_alu_imm"}, {32'd0, alu_imm}, 64'd0);
    chk({tag, "_alu_rs2_idx"}, {59'd0, alu_rs2_idx}, 64'd0);
  endtask

  function automatic logic [7:0] pick_type(input int k);
    case (k)
      0: return T_ADD;   1: return T_ADDI;  2: return T_LUI;
      3: return T_JAL;   4: return T_JALR;  5: return T_BEQ;
      6: return T_BNE;   7: return T_BGEU;  8: return T_UNK;
      default: return 8'd0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b0; in_valid = 1'b0; in_type = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_pc = '0; in_imm = '0; dut_acc = 1'b0;
    model_clear();
    #12;
    check_all_zero("reset");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // ADDI x3 = x1 + 5 with the ALU returning 7.
    issue(T_ADDI, 5'd3, 5'd1, 5'd0, 32'h0, 32'd5, w);
    chk("addi_no_wait", 64'(w), 64'd0);
    idle(3);

    // Back-to-back RAW: consumer waits exactly one cycle; an x0 producer never stalls.
    issue(T_ADD, 5'd4, 5'd1, 5'd2, 32'h10, 32'd0, w);
    issue(T_ADD, 5'd5, 5'd4, 5'd0, 32'h14, 32'd0, w);
    chk("stall_cycles", 64'(w), 64'd1);
    issue(T_ADD, 5'd0, 5'd1, 5'd2, 32'h18, 32'd0, w);
    issue(T_ADD, 5'd6, 5'd0, 5'd0, 32'h1C, 32'd0, w);
    chk("x0_no_stall", 64'(w), 64'd0);
    issue(T_ADD, 5'd7, 5'd2, 5'd7, 32'h20, 32'd0, w);
    issue(T_ADD, 5'd8, 5'd3, 5'd7, 32'h24, 32'd0, w);
    chk("rs2_stall_cycles", 64'(w), 64'd1);
    idle(3);

    // Taken BEQ: two following slots discarded, the third executes.
    issue(T_BEQ, 5'd0, 5'd1, 5'd1, 32'h100, 32'h20, w);
    issue(T_ADDI, 5'd2, 5'd1, 5'd0, 32'h104, 32'd1, w);
    chk("flush_ready1", 64'(w), 64'd0);
    issue(T_ADDI, 5'd9, 5'd1, 5'd0, 32'h108, 32'd2, w);
    chk("flush_ready2", 64'(w), 64'd0);
    issue(T_ADDI, 5'd10, 5'd1, 5'd0, 32'h120, 32'd3, w);
    idle(3);

    // JALR: target bit 0 cleared, link = pc+4.
    issue(T_JALR, 5'd1, 5'd1, 5'd1, 32'h40, 32'h1FF, w);
    idle(4);
    issue(T_JAL, 5'd6, 5'd2, 5'd2, 32'h300, 32'h50, w);
    idle(4);

    // Not-taken BNE then an immediate follower; unknown type passes silently.
    issue(T_BNE, 5'd0, 5'd1, 5'd2, 32'h200, 32'h40, w);
    issue(T_ADDI, 5'd7, 5'd3, 5'd0, 32'h204, 32'd1, w);
    chk("bne_no_gap", 64'(w), 64'd0);
    issue(T_UNK, 5'd7, 5'd1, 5'd1, 32'h208, 32'd9, w);
    idle(3);

    // Reset while flushing after a taken branch.
    issue(T_BEQ, 5'd0, 5'd2, 5'd2, 32'h400, 32'h10, w);
    in_valid = 1'b1; in_type = T_ADDI; in_rd = 5'd4; in_rs1 = 5'd1; in_rs2 = 5'd0;
    step();
    #2;
    chk("pre_reset_redirect", {63'd0, redirect_valid}, 64'd1);
    reset = 1'b0;
    #1;
    check_all_zero("flush_reset");
    in_valid = 1'b0;
    model_clear();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    issue(T_ADDI, 5'd3, 5'd1, 5'd0, 32'h0, 32'd5, w);
    chk("post_reset_no_wait", 64'(w), 64'd0);
    idle(3);

    // Random traffic with a small register pool to provoke hazards and redirects.
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_type  = pick_type($urandom_range(0, 9));
      in_rd    = 5'($urandom_range(0, 3));
      in_rs1   = 5'($urandom_range(0, 3));
      in_rs2   = 5'($urandom_range(0, 3));
      in_pc    = {$urandom_range(0, 16'hFFFF), 2'b00};
      in_imm   = 32'($urandom_range(0, 255));
      step();
    end
    idle(4);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
